s3_context_store: RTL and testbench

//  Parametrised successor to the single-entry ALU context RAM: a DEPTH-entry circular FIFO of
//  ALU context records {result, a, b, opcode}, with a built-in S3 entry/retain/exit sequencer.

---
 rtl/s3_context_store.sv | 215 +++++++++++++++++++++
 tb/tb_s3_context_store.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3_context_store.sv
`default_nettype none
// ============================================================================
// Module   : s3_context_store
// Purpose  : DEPTH-entry circular FIFO of ALU context records
//            {result, a, b, opcode} with an S3 entry/retain/exit sequencer.
//            The contents survive S3. pg_ready tells power management that
//            the store is quiescent and safe to gate.
// Ports    : clk, reset (async, active-low)
//            s3_state             S3 request level
//            wr_en, wr_*          push a record
//            rd_en                pop the oldest record
//            rd_*, rd_valid       popped record, valid one cycle after rd_en
//            count, full, empty   occupancy, registered
//            pg_ready             high while in RETAIN
//            restore_done         pulse on EXIT -> ACTIVE
//            err                  pulse on a rejected write, an overwrite
//                                 drop, or an access outside ACTIVE
//            state                0 ACTIVE, 1 ENTRY, 2 RETAIN, 3 EXIT
// Revision : 1.0  initial release
// ============================================================================
module s3_context_store #(
  parameter int DATA_W    = 4,
  parameter int OP_W      = 2,
  parameter int DEPTH     = 8,
  parameter int ENTRY_DLY = 4,
  parameter int EXIT_DLY  = 4,
  parameter int OVERWRITE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s3_state,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_result,
  input  logic [DATA_W-1:0]          wr_a,
  input  logic [DATA_W-1:0]          wr_b,
  input  logic [OP_W-1:0]            wr_opcode,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_result,
  output logic [DATA_W-1:0]          rd_a,
  output logic [DATA_W-1:0]          rd_b,
  output logic [OP_W-1:0]            rd_opcode,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       pg_ready,
  output logic                       restore_done,
  output logic                       err,
  output logic [1:0]                 state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int REC_W = 3 * DATA_W + OP_W;
  localparam int MAXD  = (ENTRY_DLY > EXIT_DLY) ? ENTRY_DLY : EXIT_DLY;
  localparam int TW    = $clog2(MAXD + 1);

  localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
  localparam logic [TW-1:0] ENTRY_LAST  = TW'(ENTRY_DLY - 1);
  localparam logic [TW-1:0] EXIT_LAST   = TW'(EXIT_DLY - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_RETAIN = 2'd2,
    ST_EXIT   = 2'd3
  } state_e;

  state_e                state_q;
  logic [TW-1:0]         tmr_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  rd_valid_q;
  logic                  pg_ready_q;
  logic                  restore_done_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rd_result_q;
  logic [DATA_W-1:0]     rd_a_q;
  logic [DATA_W-1:0]     rd_b_q;
  logic [OP_W-1:0]       rd_opcode_q;
  logic [REC_W-1:0]      mem_q [DEPTH];

  logic active;
  logic do_rd;
  logic do_wr;
  logic wr_when_full;
  logic drop_oldest;
  logic err_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    active       = (state_q == ST_ACTIVE);
    do_rd        = active && rd_en && !empty_q;
    // A simultaneous pop frees a slot, so only a lone write into a full store
    // is rejected or overwrites.
    wr_when_full = active && wr_en && full_q && !rd_en;
    drop_oldest  = wr_when_full && (OVERWRITE != 0);
    do_wr        = active && wr_en && (!full_q || rd_en || (OVERWRITE != 0));
    err_d        = (!active && (wr_en || rd_en)) || wr_when_full;

    count_d = count_q;
    if (do_wr && !do_rd && !drop_oldest) begin
      count_d = count_q + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CW'(1);
    end
  end

  // Record storage carries no reset; its contents are meaningless until
  // written and the pointers reset instead.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= {wr_result, wr_a, wr_b, wr_opcode};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_ACTIVE;
      tmr_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      rd_valid_q     <= 1'b0;
      pg_ready_q     <= 1'b0;
      restore_done_q <= 1'b0;
      err_q          <= 1'b0;
      rd_result_q    <= '0;
      rd_a_q         <= '0;
      rd_b_q         <= '0;
      rd_opcode_q    <= '0;
    end else begin
      // FIFO datapath
      if (do_wr) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_rd || drop_oldest) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_rd) begin
        {rd_result_q, rd_a_q, rd_b_q, rd_opcode_q} <= mem_q[rd_ptr_q];
      end
      count_q        <= count_d;
      full_q         <= (count_d == CNT_FULL);
      empty_q        <= (count_d == '0);
      rd_valid_q     <= do_rd;
      err_q          <= err_d;
      restore_done_q <= 1'b0;

      // S3 sequencer
      case (state_q)
        ST_ACTIVE: begin
          if (s3_state) begin
            state_q <= ST_ENTRY;
            tmr_q   <= '0;
          end
        end
        ST_ENTRY: begin
          // A withdrawn request aborts entry without any restore handshake.
          if (!s3_state) begin
            state_q <= ST_ACTIVE;
          end else if (tmr_q == ENTRY_LAST) begin
            state_q    <= ST_RETAIN;
            pg_ready_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        ST_RETAIN: begin
          if (!s3_state) begin
            state_q    <= ST_EXIT;
            pg_ready_q <= 1'b0;
            tmr_q      <= '0;
          end
        end
        ST_EXIT: begin
          if (tmr_q == EXIT_LAST) begin
            state_q        <= ST_ACTIVE;
            restore_done_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: begin
          state_q <= ST_ACTIVE;
        end
      endcase
    end
  end

  assign rd_result    = rd_result_q;
  assign rd_a         = rd_a_q;
  assign rd_b         = rd_b_q;
  assign rd_opcode    = rd_opcode_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign pg_ready     = pg_ready_q;
  assign restore_done = restore_done_q;
  assign err          = err_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_s3_context_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_s3_context_store
// Purpose  : Self-checking bench for s3_context_store. Two instances share
//            one stimulus stream, one rejecting writes when full and one
//            overwriting the oldest record. Each is compared every cycle
//            against a sequence-number based queue model and a
//            cycles-in-mode model of the S3 sequencing.
// Revision : 1.0  initial release
// ============================================================================
module tb_s3_context_store;

  localparam int DATA_W    = 4;
  localparam int OP_W      = 2;
  localparam int DEPTH     = 8;
  localparam int ENTRY_DLY = 4;
  localparam int EXIT_DLY  = 4;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int RW        = 3 * DATA_W + OP_W;
  localparam int MSZ       = 1024;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s3_state = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [DATA_W-1:0] wr_result = '0;
  logic [DATA_W-1:0] wr_a = '0;
  logic [DATA_W-1:0] wr_b = '0;
  logic [OP_W-1:0]   wr_opcode = '0;

  logic [1:0][DATA_W-1:0] rd_result;
  logic [1:0][DATA_W-1:0] rd_a;
  logic [1:0][DATA_W-1:0] rd_b;
  logic [1:0][OP_W-1:0]   rd_opcode;
  logic [1:0]             rd_valid;
  logic [1:0][CW-1:0]     count;
  logic [1:0]             full;
  logic [1:0]             empty;
  logic [1:0]             pg_ready;
  logic [1:0]             restore_done;
  logic [1:0]             err;
  logic [1:0][1:0]        state;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    s3_context_store #(
      .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH),
      .ENTRY_DLY(ENTRY_DLY), .EXIT_DLY(EXIT_DLY), .OVERWRITE(g)
    ) u_dut (
      .clk(clk), .reset(reset), .s3_state(s3_state),
      .wr_en(wr_en), .wr_result(wr_result), .wr_a(wr_a), .wr_b(wr_b),
      .wr_opcode(wr_opcode), .rd_en(rd_en),
      .rd_result(rd_result[g]), .rd_a(rd_a[g]), .rd_b(rd_b[g]),
      .rd_opcode(rd_opcode[g]), .rd_valid(rd_valid[g]), .count(count[g]),
      .full(full[g]), .empty(empty[g]), .pg_ready(pg_ready[g]),
      .restore_done(restore_done[g]), .err(err[g]), .state(state[g])
    );
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------- model
  // Records are kept by absolute sequence number: head = next to pop,
  // tail = next to push, occupancy = tail - head.
  logic [RW-1:0] m_mem [2][MSZ];
  int            m_head [2];
  int            m_tail [2];
  logic [RW-1:0] exp_rd [2];
  bit            exp_valid [2];
  bit            exp_err [2];
  int            m_mode;      // 0 ACTIVE, 1 ENTRY, 2 RETAIN, 3 EXIT
  int            m_t;         // cycles elapsed in the current timed mode
  bit            exp_restore;

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_head[g] = 0; m_tail[g] = 0;
      exp_rd[g] = '0; exp_valid[g] = 1'b0; exp_err[g] = 1'b0;
    end
    m_mode = 0; m_t = 0; exp_restore = 1'b0;
  endtask

  task automatic model_push(input int g);
    m_mem[g][m_tail[g] % MSZ] = {wr_result, wr_a, wr_b, wr_opcode};
    m_tail[g]++;
  endtask

  task automatic model_step();
    bit act;
    act = (m_mode == 0);
    for (int g = 0; g < 2; g++) begin
      int n;
      n = m_tail[g] - m_head[g];
      exp_valid[g] = 1'b0;
      exp_err[g]   = 1'b0;
      if (act) begin
        if (rd_en && n > 0) begin
          exp_rd[g]    = m_mem[g][m_head[g] % MSZ];
          exp_valid[g] = 1'b1;
          m_head[g]++;
          if (wr_en) model_push(g);
        end else if (wr_en) begin
          if (n < DEPTH) begin
            model_push(g);
          end else begin
            exp_err[g] = 1'b1;
            if (g == 1) begin
              m_head[g]++;
              model_push(g);
            end
          end
        end
      end else if (wr_en || rd_en) begin
        exp_err[g] = 1'b1;
      end
    end
    exp_restore = 1'b0;
    case (m_mode)
      0: if (s3_state) begin m_mode = 1; m_t = 0; end
      1: begin
        if (!s3_state) m_mode = 0;
        else begin
          m_t++;
          if (m_t == ENTRY_DLY) m_mode = 2;
        end
      end
      2: if (!s3_state) begin m_mode = 3; m_t = 0; end
      default: begin
        m_t++;
        if (m_t == EXIT_DLY) begin m_mode = 0; exp_restore = 1'b1; end
      end
    endcase
  endtask

  task automatic check_all();
    for (int g = 0; g < 2; g++) begin
      int n;
      n = m_tail[g] - m_head[g];
      check_eq($sformatf("count%0d", g), 32'(count[g]), 32'(n));
      check_eq($sformatf("full%0d", g), 32'(full[g]), 32'(n == DEPTH));
      check_eq($sformatf("empty%0d", g), 32'(empty[g]), 32'(n == 0));
      check_eq($sformatf("state%0d", g), 32'(state[g]), 32'(m_mode));
      check_eq($sformatf("pg_ready%0d", g), 32'(pg_ready[g]), 32'(m_mode == 2));
      check_eq($sformatf("restore_done%0d", g), 32'(restore_done[g]), 32'(exp_restore));
      check_eq($sformatf("err%0d", g), 32'(err[g]), 32'(exp_err[g]));
      check_eq($sformatf("rd_valid%0d", g), 32'(rd_valid[g]), 32'(exp_valid[g]));
      check_eq($sformatf("rd_rec%0d", g),
               32'({rd_result[g], rd_a[g], rd_b[g], rd_opcode[g]}), 32'(exp_rd[g]));
    end
  endtask

  // --------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit w, input bit r, input bit s, input logic [RW-1:0] d);
    wr_en = w; rd_en = r; s3_state = s;
    {wr_result, wr_a, wr_b, wr_opcode} = d;
    step();
  endtask

  function automatic logic [RW-1:0] mk_rec(input logic [DATA_W-1:0] res);
    return {res, DATA_W'($urandom), DATA_W'($urandom), OP_W'($urandom)};
  endfunction

  task automatic async_reset();
    wr_en = 1'b0; rd_en = 1'b0; s3_state = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit s3r;
    model_reset();
    // Reset held, then released and idle
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    reset = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 1'b0, '0);

    // FIFO order and pointer wrap, one record in flight at a time
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, mk_rec(DATA_W'(i)));
      cyc(1'b0, 1'b1, 1'b0, '0);
    end
    cyc(1'b0, 1'b1, 1'b0, '0);   // pop when empty: ignored, no err

    // Fill past DEPTH, then drain (and one extra pop)
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 1'b0, mk_rec(DATA_W'(i)));
    cyc(1'b1, 1'b1, 1'b0, mk_rec(4'hA));   // push+pop while full
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, mk_rec(4'hB));   // push+pop while empty: push only
    cyc(1'b0, 1'b1, 1'b0, '0);

    // Full S3 cycle with data retained
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 1'b0, mk_rec(DATA_W'(i + 4)));
    cyc(1'b1, 1'b0, 1'b1, mk_rec(4'hC));   // serviced in the request cycle
    repeat (5) cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b1, mk_rec(4'hD));   // write in RETAIN
    cyc(1'b0, 1'b1, 1'b1, '0);             // read in RETAIN
    repeat (2) cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, mk_rec(4'hE));   // EXIT ignores s3_state
    repeat (4) cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, '0);

    // Abort during ENTRY
    repeat (2) cyc(1'b0, 1'b0, 1'b1, '0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, '0);

    // Re-request held through EXIT -> ACTIVE -> ENTRY again
    repeat (6) cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (10) cyc(1'b0, 1'b0, 1'b1, '0);

    // Async reset while in RETAIN with five records held
    async_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, mk_rec(DATA_W'(i)));
    repeat (6) cyc(1'b0, 1'b0, 1'b1, '0);
    async_reset();
    repeat (3) cyc(1'b0, 1'b1, 1'b0, '0);

    // Randomised traffic with slowly toggling S3 requests
    s3r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(24) == 0) s3r = ~s3r;
      cyc(1'($urandom_range(1)), ($urandom_range(2) == 0), s3r,
          mk_rec(DATA_W'($urandom)));
    end
    repeat (12) cyc(1'b0, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
